// File: rtl/systolic_pkg.sv
// Shared types for the systolic drain path: deskew FSM states and the per-lane word type.
package systolic_pkg;

  localparam int LANE_W = 32;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } deskew_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Enable-gated shift register of DEPTH words; DEPTH 0 degenerates to a plain wire.
module skew_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst, en};
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] sr_q [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else if (en) begin
          sr_q[0] <= d;
          for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
      end

      assign q = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_deskew_reader.sv
// Drains the skewed systolic result buffer and emits one aligned N_SIZE-lane row per beat.
// Optional feature: define DESKEW_ROW_IDX_EN to add the out_row_idx output.
module systolic_deskew_reader
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH_output = 32,
  parameter int N_SIZE           = 32,
  parameter int MAX_ROWS         = 512,
  parameter int ADDR_WIDTH       = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              cfg_rows,
  output logic                               busy,
  output logic                               done,
  output logic [ADDR_WIDTH-1:0]              rd_addr,
  input  logic [DATAWIDTH_output*N_SIZE-1:0] rd_data,
  output logic                               out_valid,
  input  logic                               out_ready,
`ifdef DESKEW_ROW_IDX_EN
  output logic [ADDR_WIDTH-1:0]              out_row_idx,
`endif
  output logic [DATAWIDTH_output*N_SIZE-1:0] out_data
);

  localparam int DW = DATAWIDTH_output;

  generate
    if ((MAX_ROWS + N_SIZE - 2) >= (1 << ADDR_WIDTH)) begin : g_bad_cfg
      $error("ADDR_WIDTH too small for MAX_ROWS + N_SIZE - 2");
    end
  endgenerate

  deskew_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   cur_q;
  logic [ADDR_WIDTH-1:0]   last_q;
  logic                    prime_q;
  logic                    have_q;
  logic                    valid_q;
  logic [DW*N_SIZE-1:0]    data_q;
  logic [DW*N_SIZE-1:0]    lane_cat;

  logic adv, consume, at_last, emit, start_ok;

  // have_q: rd_data holds word cur_q not yet pushed into the delay lines
  assign adv      = !valid_q || out_ready;
  assign consume  = have_q && adv;
  assign at_last  = (cur_q == last_q);
  assign emit     = consume && (cur_q >= ADDR_WIDTH'(N_SIZE - 1));
  assign start_ok = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (cfg_rows == '0) ? DONE : FILL;
      FILL:    if (consume && cur_q == ADDR_WIDTH'(N_SIZE - 2)) state_d = STREAM;
      // once the last word is consumed, the row on the output is the final one
      STREAM:  if (valid_q && out_ready && !have_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == FILL) || (state_q == STREAM);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= '0;
      last_q  <= '0;
      prime_q <= 1'b0;
      have_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (start_ok) begin
      cur_q   <= '0;
      last_q  <= cfg_rows + ADDR_WIDTH'(N_SIZE - 2);
      prime_q <= (cfg_rows != '0);
      have_q  <= 1'b0;
    end else begin
      prime_q <= 1'b0;
      if (prime_q) begin
        have_q <= 1'b1;
      end else if (consume) begin
        if (at_last) have_q <= 1'b0;
        else         cur_q  <= cur_q + 1'b1;
      end
      if (adv)  valid_q <= emit;
      if (emit) data_q  <= lane_cat;
    end
  end

`ifdef DESKEW_ROW_IDX_EN
  logic [ADDR_WIDTH-1:0] row_idx_q;

  always_ff @(posedge clk) begin
    if (rst)       row_idx_q <= '0;
    else if (emit) row_idx_q <= cur_q - ADDR_WIDTH'(N_SIZE - 1);
  end

  assign out_row_idx = row_idx_q;
`endif

  // a stalled beat re-issues cur_q so rd_data still shows that word next cycle
  assign rd_addr = (consume && !at_last) ? cur_q + 1'b1 : cur_q;

  generate
    for (genvar gi = 0; gi < N_SIZE; gi++) begin : g_lane
      skew_delay_line #(
        .WIDTH(DW),
        .DEPTH(N_SIZE - 1 - gi)
      ) u_dly (
        .clk(clk),
        .rst(rst),
        .en (consume),
        .d  (rd_data[gi*DW +: DW]),
        .q  (lane_cat[gi*DW +: DW])
      );
    end
  endgenerate

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_systolic_deskew_reader.sv
// Directed bench for systolic_deskew_reader with N_SIZE=4 and a 1-cycle-latency buffer model.
module tb_systolic_deskew_reader;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     cfg_rows;
  logic              busy;
  logic              done;
  logic [AW-1:0]     rd_addr;
  logic [DW*N-1:0]   rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW*N-1:0]   out_data;
`ifdef DESKEW_ROW_IDX_EN
  logic [AW-1:0]     out_row_idx;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_deskew_reader #(
    .DATAWIDTH_output(DW),
    .N_SIZE          (N),
    .MAX_ROWS        (512),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_rows   (cfg_rows),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef DESKEW_ROW_IDX_EN
    .out_row_idx(out_row_idx),
`endif
    .out_data   (out_data)
  );

  // buffer word a, lane j = {a, j}
  function automatic logic [DW*N-1:0] buf_word(int a);
    logic [DW*N-1:0] w;
    lane_t l;
    for (int j = 0; j < N; j++) begin
      l = {16'(a), 16'(j)};
      w[j*DW +: DW] = l;
    end
    return w;
  endfunction

  // aligned row r, lane j = {r+j, j}
  function automatic logic [DW*N-1:0] exp_row(int r);
    logic [DW*N-1:0] w;
    lane_t l;
    for (int j = 0; j < N; j++) begin
      l = {16'(r + j), 16'(j)};
      w[j*DW +: DW] = l;
    end
    return w;
  endfunction

  always @(posedge clk) rd_data <= buf_word(int'(rd_addr));

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"},  out_data, 0);
    check({tag, "_addr"},  rd_addr, 0);
`ifdef DESKEW_ROW_IDX_EN
    check({tag, "_idx"},   out_row_idx, 0);
`endif
  endtask

  // rnd: random out_ready; inj: stray start in STREAM; rst_mid: reset after row 3
  task automatic drain(int rows, bit rnd, bit inj, bit rst_mid);
    int k = 0;
    int row_n = 0;
    bit prev_stall = 1'b0;
    bit rst_pend = 1'b0;
    bit fin = 1'b0;
    logic [AW-1:0]   prev_addr = '0;
    logic [DW*N-1:0] prev_data = '0;
    @(negedge clk);
    start = 1'b1;
    cfg_rows = AW'(rows);
    out_ready = 1'b1;
    while (!fin) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (rst_pend) begin
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("midreset");
        rst = 1'b0;
        fin = 1'b1;
      end else begin
        if (inj && k == 8) begin
          start = 1'b1;
          cfg_rows = AW'(2);
        end
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (!rnd && rows > 0 && k <= rows + N - 1) check("rd_addr_seq", rd_addr, k - 1);
        if (busy) check("rd_addr_range", (int'(rd_addr) <= rows + N - 2), 1);
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, prev_data);
        end
        if (out_valid && !out_ready) check("stall_addr", rd_addr, prev_addr);
        if (out_valid && out_ready) begin
          check($sformatf("row%0d_data", row_n), out_data, exp_row(row_n));
          if (!rnd) check($sformatf("row%0d_cycle", row_n), k, 6 + row_n);
`ifdef DESKEW_ROW_IDX_EN
          check($sformatf("row%0d_idx", row_n), out_row_idx, row_n);
`endif
          row_n++;
          if (rst_mid && row_n == 4) rst_pend = 1'b1;
        end
        if (done) begin
          check("done_rows", row_n, rows);
          if (!rnd) check("done_cycle", k, (rows == 0) ? 1 : rows + 6);
          check("done_busy", busy, 0);
          fin = 1'b1;
        end
        if (k > 300) begin
          check("timeout", 0, 1);
          fin = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        prev_addr  = rd_addr;
        prev_data  = out_data;
      end
    end
    out_ready = 1'b1;
    $display("drain rows=%0d rnd=%0d inj=%0d rst_mid=%0d: %0d rows seen in %0d cycles",
             rows, rnd, inj, rst_mid, row_n, k);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_rows = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    drain(8, 1'b0, 1'b0, 1'b0);
    drain(8, 1'b1, 1'b0, 1'b0);
    drain(1, 1'b0, 1'b0, 1'b0);
    drain(0, 1'b0, 1'b0, 1'b0);
    drain(8, 1'b0, 1'b1, 1'b0);
    drain(8, 1'b0, 1'b0, 1'b1);
    drain(8, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    check("final_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
